imem_arbiter: RTL

- Shares the single-port instruction memory between two requesters: the IF-stage fetch unit (reads) and the program loader/debug port (writes and readback).
- Runs a boot phase after reset in which only the loader is served, so the program image is written before fetch starts.
- In run mode it arbitrates per cycle. The loader is capped at a fixed burst length so fetch is never starved.
- Sits between the PC/IF logic and the memory array; it converts byte PCs to word indices.

---
 rtl/imem_arbiter_if.sv | 12 +
 rtl/imem_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: single-port instruction memory bus between the arbiter and the memory array
interface imem_arbiter_if #(
  parameter int AW = 7
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  modport master(output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave(input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: boot-then-run arbiter sharing instruction memory between fetch and loader
module imem_arbiter #(
  parameter int          DEPTH    = 100,
  parameter int          AW       = 7,
  parameter int          LD_BURST = 4,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_pc,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  output logic                  f_err,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [AW-1:0]         l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  input  logic                  load_done,
  output logic                  boot_busy,
  imem_arbiter_if.master        mem
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        boot, oor, ld_win;
  logic        f_v, f_e, l_v;
  logic [31:0] f_hold, l_hold;
  always_comb begin
    boot          = state == BOOT;
    oor           = (f_pc[1:0] != 2'b00) || ((f_pc >> 2) >= 32'(DEPTH));
    ld_win        = l_req && (!f_req || cnt < 4'(LD_BURST));
    l_gnt         = !reset && (boot ? l_req : ld_win);
    f_gnt         = !reset && !boot && f_req && !ld_win;
    state_n       = (boot && load_done) ? RUN : state;
    boot_busy     = boot;
    mem.mem_en    = l_gnt || (f_gnt && !oor);
    mem.mem_we    = l_gnt && l_we;
    mem.mem_addr  = l_gnt ? l_addr : f_pc[AW+1:2];
    mem.mem_wdata = l_wdata;
    f_rvalid      = f_v && !reset;
    f_err         = f_v && f_e && !reset;
    l_rvalid      = l_v && !reset;
    f_rdata       = f_rvalid ? (f_e ? NOP_WORD : mem.mem_rdata) : f_hold;
    l_rdata       = l_rvalid ? mem.mem_rdata : l_hold;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BOOT;
      cnt    <= '0;
      f_v    <= 1'b0;
      f_e    <= 1'b0;
      l_v    <= 1'b0;
      f_hold <= NOP_WORD;
      l_hold <= '0;
    end else begin
      state  <= state_n;
      cnt    <= (f_gnt || !l_req) ? 4'd0 :
                (!boot && l_gnt && f_req && cnt < 4'(LD_BURST)) ? cnt + 4'd1 : cnt;
      f_v    <= f_gnt;
      f_e    <= f_gnt && oor;
      l_v    <= l_gnt && !l_we;
      f_hold <= f_rvalid ? f_rdata : f_hold;
      l_hold <= l_rvalid ? l_rdata : l_hold;
    end
  end
endmodule
